// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Generic pipeline stage register between CPU stages (IF/ID, ID/EX, EX/MEM,
//   MEM/WB). It uses a valid/ready handshake and can add an optional
//   two-entry skid buffer. A synchronous flush clears the stage and inserts a
//   bubble, and a saturating counter records stall cycles.
//   All state updates happen on the falling edge of CLK.
//
// Ports
//   CLK        clock (falling-edge active)
//   Resetn     synchronous active-low reset
//   in_valid   upstream entry present
//   in_ready   stage can accept an entry this cycle
//   in_data    upstream data payload  [WIDTH]
//   in_ctrl    upstream control payload [CTRL_W]
//   flush      synchronous kill of all held entries
//   out_valid  head entry valid
//   out_ready  downstream accepts head entry
//   out_data   head data payload (0 when empty)
//   out_ctrl   head control payload (BUBBLE_CTRL when empty)
//   occupancy  number of valid entries, 0..2
//   stall_cnt  saturating count of edges with out_valid && !out_ready
module pipe_stage_buf #(
  parameter int                 WIDTH       = 32,
  parameter int                 CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter int                 SKID        = 1,
  parameter int                 CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Head (H) drives the outputs; skid (S) only ever fills when SKID != 0.
  logic              h_valid, s_valid;
  logic [WIDTH-1:0]  h_data,  s_data;
  logic [CTRL_W-1:0] h_ctrl,  s_ctrl;
  logic [CNT_W-1:0]  stall_q;

  logic              h_valid_n, s_valid_n;
  logic [WIDTH-1:0]  h_data_n,  s_data_n;
  logic [CTRL_W-1:0] h_ctrl_n,  s_ctrl_n;
  logic [CNT_W-1:0]  stall_n;

  logic in_xfer;
  logic out_xfer;

  // With a skid entry, in_ready comes straight from the s_valid flop, so it
  // has no combinational path from out_ready. Without one, a full head can
  // still accept when it is being drained in the same cycle.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = !s_valid;
    end else begin : g_pass_ready
      assign in_ready = !h_valid || out_ready;
    end
  endgenerate

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = h_valid && out_ready;

  always_comb begin
    h_valid_n = h_valid;
    h_data_n  = h_data;
    h_ctrl_n  = h_ctrl;
    s_valid_n = s_valid;
    s_data_n  = s_data;
    s_ctrl_n  = s_ctrl;
    stall_n   = stall_q;

    // The stall counter ignores flush because it reflects the handshake seen
    // downstream, not what the stage holds.
    if (h_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_n = stall_q + 1'b1;

    if (flush) begin
      h_valid_n = 1'b0;
      h_data_n  = '0;
      h_ctrl_n  = BUBBLE_CTRL;
      s_valid_n = 1'b0;
      s_data_n  = '0;
      s_ctrl_n  = BUBBLE_CTRL;
    end else if (!h_valid) begin
      // S is empty here because S valid implies H valid.
      if (in_xfer) begin
        h_valid_n = 1'b1;
        h_data_n  = in_data;
        h_ctrl_n  = in_ctrl;
      end
    end else if (out_xfer) begin
      if (s_valid) begin
        h_valid_n = 1'b1;
        h_data_n  = s_data;
        h_ctrl_n  = s_ctrl;
        s_valid_n = 1'b0;
        s_data_n  = '0;
        s_ctrl_n  = BUBBLE_CTRL;
      end else if (in_xfer) begin
        h_valid_n = 1'b1;
        h_data_n  = in_data;
        h_ctrl_n  = in_ctrl;
      end else begin
        h_valid_n = 1'b0;
        h_data_n  = '0;
        h_ctrl_n  = BUBBLE_CTRL;
      end
    end else if (in_xfer && (SKID != 0)) begin
      s_valid_n = 1'b1;
      s_data_n  = in_data;
      s_ctrl_n  = in_ctrl;
    end
  end

  always_ff @(negedge CLK) begin
    if (!Resetn) begin
      h_valid <= 1'b0;
      h_data  <= '0;
      h_ctrl  <= BUBBLE_CTRL;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ctrl  <= BUBBLE_CTRL;
      stall_q <= '0;
    end else begin
      h_valid <= h_valid_n;
      h_data  <= h_data_n;
      h_ctrl  <= h_ctrl_n;
      s_valid <= s_valid_n;
      s_data  <= s_data_n;
      s_ctrl  <= s_ctrl_n;
      stall_q <= stall_n;
    end
  end

  assign out_valid = h_valid;
  assign out_data  = h_data;
  assign out_ctrl  = h_ctrl;
  assign occupancy = {1'b0, h_valid} + {1'b0, s_valid};
  assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with valid/ready handshake, optional two-entry skid buffer, synchronous flush with bubble insertion, and a stall-cycle counter. It is the generic replacement for the fixed per-stage latches between CPU pipeline stages: IF/ID, ID/EX, EX/MEM and MEM/WB. Control fields and data fields are carried as separate buses, so a flushed or empty stage presents a known NOP control word downstream.

## Interface
- WIDTH, 32: data payload width, covering operands, PC, immediate and register addresses concatenated by the instantiator.
- CTRL_W, 16: control payload width, covering MemWr, Branch, Jump, MemtoReg, RegWr, ALU selects and similar.
- BUBBLE_CTRL, {CTRL_W{1'b0}}: control word presented whenever the stage holds no valid entry.
- SKID, 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single entry with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  clock; all state updates on the falling edge.
- Resetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  WIDTH  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- flush  in  1  synchronous kill of all held entries; used for branch/jump redirect.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  WIDTH  head data payload.
- out_ctrl  out  CTRL_W  head control payload; equals BUBBLE_CTRL when out_valid=0.
- occupancy  out  2  number of valid entries (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  saturating count of edges with out_valid=1 and out_ready=0.

## Operation
- **Storage:** head entry (H) drives the outputs. The skid entry (S) exists only when SKID=1.
- **Invariant:** S valid implies H valid.
- **Transfer rule:** an input transfer occurs when in_valid && in_ready at the edge. An output transfer occurs when out_valid && out_ready at the edge.
- **in_ready, SKID=1:** in_ready = !S.valid. It is taken from a flop, with no combinational path from out_ready.
- **in_ready, SKID=0:** in_ready = !H.valid || out_ready.
- **Next-state, flush=0, evaluated per edge:**
  - H empty, input transfer: H <= input.
  - H full, output transfer, S full: H <= S, S cleared. No input is accepted, because in_ready=0.
  - H full, output transfer, S empty, input transfer: H <= input.
  - H full, output transfer, no input transfer: H cleared.
  - H full, no output transfer, input transfer (SKID=1 only): S <= input.
  - H full, no output transfer, no input transfer: hold.
- **Cleared entry:** valid=0, data=0, ctrl=BUBBLE_CTRL. out_data and out_ctrl therefore always show a deterministic bubble when empty.
- **flush=1:** H and S are both cleared. flush dominates any simultaneous input transfer, and that input entry is discarded.
  - Any simultaneous output transfer is still counted as completed by downstream.
  - stall_cnt is unaffected by flush.
- **stall_cnt:** increments by 1 on each edge with out_valid && !out_ready, then saturates at all-ones. No wrap.
- **occupancy:** H.valid + S.valid.

## Timing
- **Reset** (Resetn=0 at a falling edge), all outputs:
  - out_valid=0
  - out_data=0
  - out_ctrl=BUBBLE_CTRL
  - occupancy=0
  - stall_cnt=0
  - in_ready=1, both when SKID=1 and when SKID=0
- **Reset priority:** reset overrides flush and all transfers. Reset mid-stream drops both entries without emitting them.
- **Latency:** 1 edge from input transfer into an empty stage to out_valid=1.
- **Throughput:** 1 entry/cycle when out_ready is held high.
- **SKID=1 backpressure:** after out_ready drops, the stage accepts at most one further entry, into S. in_ready deasserts on the following edge.
- **SKID=1 release:** when out_ready returns, in_ready reasserts one edge after S drains.
- **Ordering:** strict FIFO order. No entry is duplicated or lost except by flush or reset.
- **flush timing:** outputs show the bubble immediately after the flush edge. An input presented on the next edge is accepted normally.

## Test plan
- **Reset:** assert Resetn=0 for 2 edges while in_valid=1, then release. Required: out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0, stall_cnt=0, in_ready=1. The first entry accepted after release is 0x11, appearing after 1 edge.
- **Streaming:** out_ready=1, push data 0x1..0x8 back-to-back. Required: outputs 0x1..0x8 in order, one per edge, 1-edge latency, occupancy never exceeds 1.
- **Skid backpressure (SKID=1):** stream 0xA,0xB,0xC and drop out_ready after 0xA appears. Required:
  - H=0xA, S=0xB, occupancy=2, in_ready=0, 0xC held upstream.
  - stall_cnt increments each stalled edge.
  - On out_ready=1, the stage emits 0xA, then 0xB, then 0xC.
- **Flush collision:** H=0x5, S=0x6, in_valid=1 with 0x7, assert flush for 1 edge. Required: out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0. 0x7 is never emitted, and the next pushed 0x8 is output 1 edge later.
- **Counter saturation:** CNT_W=4, hold out_valid=1 with out_ready=0 for 20 edges. Required: stall_cnt reaches 15 and stays at 15.
- **SKID=0 pass-through:** hold out_ready low with H full. Required: in_ready=0 in the same cycle. Raising out_ready with in_valid=1 gives in_ready=1 combinationally, and the new entry replaces H on that edge.
